// File: rtl/reset_sequencer.sv
// Staged reset release: each domain leaves reset only after the previous one acknowledges.
// Define ACK_TIMEOUT_EN to build the per-stage acknowledge timeout and FAULT state.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                          iclk,
  input  logic                          irst_n,
  input  logic [NUM_STAGES-1:0]         istage_ack,
  output logic [NUM_STAGES-1:0]         orst_n_stage,
  output logic                          osys_ready,
  output logic                          otimeout_err,
  output logic [$clog2(NUM_STAGES)-1:0] ofault_stage
);
  localparam int unsigned IDX_W  = $clog2(NUM_STAGES);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (NUM_STAGES < 2 || NUM_STAGES > 16 || HOLD_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_param
    $error("reset_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_ACK,
    S_READY
`ifdef ACK_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;

  state_t                  state, state_d;
  logic [HOLD_W-1:0]       hold_cnt, hold_cnt_d;
  logic [IDX_W-1:0]        idx, idx_d;
  logic [NUM_STAGES-1:0]   rst_d;
  logic                    ready_d;
  logic                    hold_done;
  logic                    ack_cur;
  logic                    last_stage;

  assign hold_done  = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign ack_cur    = istage_ack[idx];
  assign last_stage = (idx == IDX_W'(NUM_STAGES - 1));

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             tmo_hit;
  logic             err_d;
  logic [IDX_W-1:0] fstage_d;

  assign tmo_hit = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
`else
  assign otimeout_err = 1'b0;
  assign ofault_stage = '0;
`endif

  // State, counters and registered outputs
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state        <= S_HOLD;
      hold_cnt     <= '0;
      idx          <= '0;
      orst_n_stage <= '0;
      osys_ready   <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      tmo_cnt      <= '0;
      otimeout_err <= 1'b0;
      ofault_stage <= '0;
`endif
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_cnt_d;
      idx          <= idx_d;
      orst_n_stage <= rst_d;
      osys_ready   <= ready_d;
`ifdef ACK_TIMEOUT_EN
      tmo_cnt      <= tmo_cnt_d;
      otimeout_err <= err_d;
      ofault_stage <= fstage_d;
`endif
    end
  end

  // Next state and counters; counters clear on every state or stage change
  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    idx_d      = idx;
`ifdef ACK_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt;
`endif
    case (state)
      S_HOLD: begin
        if (hold_done) begin
          state_d    = S_WAIT_ACK;
          hold_cnt_d = '0;
`ifdef ACK_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt + HOLD_W'(1);
        end
      end
      S_WAIT_ACK: begin
        if (ack_cur) begin
          if (last_stage) begin
            state_d = S_READY;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
`ifdef ACK_TIMEOUT_EN
          tmo_cnt_d = '0;
        end else if (tmo_hit) begin
          state_d   = S_FAULT;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
`endif
        end
      end
      default: ;
    endcase
  end

  // Next values of the registered outputs; released stages stay released
  always_comb begin
    rst_d   = orst_n_stage;
    ready_d = osys_ready;
`ifdef ACK_TIMEOUT_EN
    err_d    = otimeout_err;
    fstage_d = ofault_stage;
`endif
    case (state)
      S_HOLD: begin
        if (hold_done) rst_d[0] = 1'b1;
      end
      S_WAIT_ACK: begin
        if (ack_cur) begin
          if (last_stage) ready_d = 1'b1;
          else            rst_d   = orst_n_stage | {orst_n_stage[NUM_STAGES-2:0], 1'b1};
        end
`ifdef ACK_TIMEOUT_EN
        else if (tmo_hit) begin
          rst_d    = '0;
          err_d    = 1'b1;
          fstage_d = idx;
        end
`endif
      end
      default: ;
    endcase
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the clean, debounced system reset and releases the design's reset domains one stage at a time. Each stage must acknowledge before the next stage leaves reset. The block sits directly downstream of the reset debouncer and drives the per-subsystem reset lines plus a global ready flag. An optional acknowledge timeout flags a stage that never comes out of reset.

## Interface
- NUM_STAGES, 4: number of sequenced reset outputs; legal range 2..16.
- HOLD_CYCLES, 16: cycles all stages stay in reset after irst_n deasserts; must be ≥1.
- ACK_TIMEOUT, 255: max WAIT_ACK cycles per stage before fault; must be ≥1; used only with ACK_TIMEOUT_EN.
- iclk  input  1  clock.
- irst_n  input  1  reset, synchronous, active-low; clock iclk.
- istage_ack  input  NUM_STAGES  per-stage "out of reset and running" acknowledge; synchronous to iclk (the caller synchronizes).
- orst_n_stage  output  NUM_STAGES  per-stage reset, active-low; bit 0 is released first.
- osys_ready  output  1  high once every stage is released and acknowledged.
- otimeout_err  output  1  sticky fault flag; constant 0 without ACK_TIMEOUT_EN.
- ofault_stage  output  clog2(NUM_STAGES)  index of the stage that timed out; valid while otimeout_err=1.

## Operation
- States: HOLD, WAIT_ACK, READY, FAULT.
- irst_n=0 sampled at any edge, in any state, forces the following on that edge:
  - state=HOLD; hold counter=0; stage index=0; timeout counter=0.
  - orst_n_stage=0, osys_ready=0, otimeout_err=0, ofault_stage=0.
- These values are also the reset value of every output.
- HOLD: the hold counter increments each edge while irst_n=1. On the edge where the counter equals HOLD_CYCLES-1:
  - orst_n_stage[0]←1;
  - state←WAIT_ACK;
  - timeout counter←0.
- WAIT_ACK (stage idx):
  - istage_ack[idx]=1 and idx<NUM_STAGES-1: orst_n_stage[idx+1]←1; idx←idx+1; timeout counter←0; stay in WAIT_ACK.
  - istage_ack[idx]=1 and idx=NUM_STAGES-1: osys_ready←1; state←READY.
  - istage_ack[idx]=0: timeout counter increments (ACK_TIMEOUT_EN only).
- Acks of stages other than idx are ignored. A stale ack already high at release is accepted on the first WAIT_ACK edge.
- READY is terminal until irst_n=0. Ack drops in READY are ignored; all outputs hold.
- FAULT (ACK_TIMEOUT_EN only):
  - all orst_n_stage←0; osys_ready stays 0; otimeout_err←1; ofault_stage←idx.
  - Terminal until irst_n=0.
- Released stages stay released. orst_n_stage bits rise monotonically in index order, except on entry to reset or FAULT.
- Counter widths are clog2 of their maximum value. Counters never wrap: they are cleared on every state or stage change.

## Timing
- Edge 1 is the first edge that samples irst_n=1. orst_n_stage[0] rises at edge HOLD_CYCLES.
- Stage idx released at edge k: its ack is first sampled at edge k+1. The next stage is released on the same edge its predecessor's ack is sampled.
  - Minimum spacing between stage releases: 1 cycle.
  - Best-case release-to-ready after stage 0: NUM_STAGES edges.
- Timeout: an ack absent on ACK_TIMEOUT consecutive WAIT_ACK edges for one stage causes FAULT on the ACK_TIMEOUT-th edge.
- Ack and timeout on the same edge: the ack wins.
- irst_n=0 on the same edge as any ack or timeout: reset wins.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- ACK_TIMEOUT_EN defined:
  - timeout counter, FAULT state, otimeout_err and ofault_stage logic are built.
- ACK_TIMEOUT_EN undefined:
  - no timeout counter and no FAULT state; WAIT_ACK waits indefinitely.
  - otimeout_err and ofault_stage are tied to 0.
  - ACK_TIMEOUT is ignored.

## Test plan
Default parameters unless noted; ACK_TIMEOUT_EN defined unless noted.
- Nominal: irst_n low 3 cycles, then high; each ack returned 2 cycles after its release. Required:
  - orst_n_stage reads 0001 at edge 16, then 0011, 0111, 1111 at 3-cycle spacing.
  - osys_ready=1 three cycles after 1111.
- Pre-asserted acks: istage_ack=1111 throughout. Required:
  - stages release on consecutive edges 16..19;
  - osys_ready=1 at edge 20.
- Timeout (ACK_TIMEOUT=8): acks 0 and 1 returned, stage 2 never acks. Required:
  - FAULT on the 8th WAIT_ACK edge of stage 2;
  - orst_n_stage=0000, otimeout_err=1, ofault_stage=2, osys_ready=0.
- Boundary: stage 2 ack arrives exactly on the 8th WAIT_ACK edge. Required: no fault; stage 3 is released.
- Reset mid-sequence: irst_n=0 for 1 cycle while in WAIT_ACK on stage 1. Required:
  - next edge: all outputs 0;
  - sequence restarts and stage 0 is re-released 16 edges after irst_n returns high.
- Macro off: stage 2 never acks for 1000 cycles. Required: orst_n_stage holds 0111, otimeout_err stays 0, no FAULT.
